// File: rtl/sensor_hub_pkg.sv
// Shared types and constants for the sensor request router.
package sensor_hub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    DISPATCH,
    WAIT_SENSOR,
    SEND_STATUS,
    WAIT_TX_STATUS,
    SEND_DATA,
    WAIT_TX_DATA
  } state_t;

  localparam logic [7:0] STATUS_OK       = 8'h00;
  localparam logic [7:0] STATUS_BAD_ADDR = 8'hE0;
  localparam logic [7:0] STATUS_TIMEOUT  = 8'hE1;

  localparam int unsigned REQ_BYTES  = 2;
  localparam int unsigned RESP_BYTES = 2;

endpackage

// File: rtl/sensor_request_router_cycle_timeout.sv
// Shared wait timer: counts while run is high and flags the final allowed cycle.
module cycle_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired_c
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] count;

  // Saturates at TIMEOUT_CYCLES so a stalled owner never sees a wrapped count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != TW'(TIMEOUT_CYCLES))) begin
      count <= count + TW'(1);
    end
  end

  // High in the TIMEOUT_CYCLES-th running cycle, so the owner leaves after exactly that many.
  assign expired_c = run && !clear && (count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sensor_request_router.sv
// Two-byte UART request router: addresses one sensor, waits with timeout, returns status and data.
module sensor_request_router
  import sensor_hub_pkg::*;
#(
  parameter int unsigned NUM_SENSORS    = 32,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              rx_valid,
  input  logic [DATA_WIDTH-1:0]             rx_data,
  output logic [NUM_SENSORS-1:0]            sensor_enable,
  output logic [DATA_WIDTH-1:0]             sensor_request,
  input  logic [NUM_SENSORS*DATA_WIDTH-1:0] sensor_data,
  input  logic [NUM_SENSORS-1:0]            sensor_finished,
  output logic                              tx_start,
  output logic [DATA_WIDTH-1:0]             tx_data,
  input  logic                              tx_busy,
  input  logic                              tx_done,
  output logic                              busy,
  output logic [7:0]                        error_count
);

  localparam int unsigned SW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

  state_t                  state, state_d;
  logic [DATA_WIDTH-1:0]   addr, addr_d;
  logic [DATA_WIDTH-1:0]   cmd, cmd_d;
  logic [DATA_WIDTH-1:0]   status, status_d;
  logic [DATA_WIDTH-1:0]   data, data_d;
  logic [NUM_SENSORS-1:0]  enable_d;
  logic [DATA_WIDTH-1:0]   request_d;
  logic                    tx_start_d;
  logic [DATA_WIDTH-1:0]   tx_data_d;
  logic                    busy_d;
  logic [7:0]              error_count_d;
  logic [1:0]              err_inc;
  logic [8:0]              err_sum;
  logic                    timer_clear;
  logic                    timer_run;
  logic                    expired;
  logic                    addr_valid;
  logic [SW-1:0]           sel;
  logic [DATA_WIDTH-1:0]   chan_data [NUM_SENSORS];

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
    assign chan_data[i] = sensor_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Whole address byte is range-checked; sel is only used once the address is known good.
  assign addr_valid = (32'(addr) < NUM_SENSORS);
  assign sel        = SW'(addr);

  assign timer_run   = (state == GET_CMD) || (state == WAIT_SENSOR);
  assign timer_clear = ((state == IDLE) && rx_valid) || (state == DISPATCH);

  cycle_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .run      (timer_run),
    .expired_c(expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      addr           <= '0;
      cmd            <= '0;
      status         <= '0;
      data           <= '0;
      sensor_enable  <= '0;
      sensor_request <= '0;
      tx_start       <= 1'b0;
      tx_data        <= '0;
      busy           <= 1'b0;
      error_count    <= '0;
    end else begin
      state          <= state_d;
      addr           <= addr_d;
      cmd            <= cmd_d;
      status         <= status_d;
      data           <= data_d;
      sensor_enable  <= enable_d;
      sensor_request <= request_d;
      tx_start       <= tx_start_d;
      tx_data        <= tx_data_d;
      busy           <= busy_d;
      error_count    <= error_count_d;
    end
  end

  // Next-state, latched transaction fields and registered outputs.
  always_comb begin
    state_d    = state;
    addr_d     = addr;
    cmd_d      = cmd;
    status_d   = status;
    data_d     = data;
    enable_d   = sensor_enable;
    request_d  = sensor_request;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    // Bytes arriving outside request assembly are dropped and counted.
    err_inc    = (rx_valid && (state != IDLE) && (state != GET_CMD)) ? 2'd1 : 2'd0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          state_d = GET_CMD;
        end
      end
      GET_CMD: begin
        if (rx_valid) begin
          cmd_d = rx_data;
          if (!addr_valid) begin
            status_d = DATA_WIDTH'(STATUS_BAD_ADDR);
            data_d   = '0;
            err_inc  = err_inc + 2'd1;
            state_d  = SEND_STATUS;
          end else begin
            state_d = DISPATCH;
          end
        end else if (expired) begin
          err_inc = err_inc + 2'd1;
          state_d = IDLE;
        end
      end
      DISPATCH: begin
        enable_d  = NUM_SENSORS'(1) << sel;
        request_d = cmd;
        state_d   = WAIT_SENSOR;
      end
      WAIT_SENSOR: begin
        if (sensor_finished[sel]) begin
          data_d   = chan_data[sel];
          status_d = DATA_WIDTH'(STATUS_OK);
          enable_d = '0;
          state_d  = SEND_STATUS;
        end else if (expired) begin
          data_d   = '0;
          status_d = DATA_WIDTH'(STATUS_TIMEOUT);
          enable_d = '0;
          err_inc  = err_inc + 2'd1;
          state_d  = SEND_STATUS;
        end
      end
      SEND_STATUS: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = status;
          state_d    = WAIT_TX_STATUS;
        end
      end
      WAIT_TX_STATUS: begin
        if (tx_done) state_d = SEND_DATA;
      end
      SEND_DATA: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = data;
          state_d    = WAIT_TX_DATA;
        end
      end
      WAIT_TX_DATA: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_sum       = {1'b0, error_count} + 9'(err_inc);
    error_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    busy_d        = (state_d != IDLE);
  end

endmodule

// File: tb/tb_sensor_request_router.sv
// Randomized transaction-level bench for sensor_request_router with a small UART TX responder.
module tb_sensor_request_router;
  import sensor_hub_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic              clock;
  logic              reset_n;
  logic              rx_valid;
  logic [DW-1:0]     rx_data;
  logic [NS-1:0]     sensor_enable;
  logic [DW-1:0]     sensor_request;
  logic [NS*DW-1:0]  sensor_data;
  logic [NS-1:0]     sensor_finished;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic              tx_busy;
  logic              tx_done;
  logic              busy;
  logic [7:0]        error_count;

  int checks;
  int failures;
  int exp_err;
  logic hold_busy;
  logic [DW-1:0] tx_q[$];

  sensor_request_router #(
    .NUM_SENSORS   (NS),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .sensor_enable  (sensor_enable),
    .sensor_request (sensor_request),
    .sensor_data    (sensor_data),
    .sensor_finished(sensor_finished),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .busy           (busy),
    .error_count    (error_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // UART transmitter stand-in: 3-cycle byte time, records each byte sent.
  initial begin
    logic [DW-1:0] b;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      tx_done = 1'b0;
      if (tx_start) begin
        check_eq("tx_start_while_busy", 32'(tx_busy), 32'd0);
        b = tx_data;
        tx_q.push_back(b);
        tx_busy = 1'b1;
        repeat (3) begin
          @(posedge clock);
          #1;
          check_eq("tx_data_hold", 32'(tx_data), 32'(b));
          check_eq("tx_start_pulse", 32'(tx_start), 32'd0);
        end
        tx_done = 1'b1;
        tx_busy = 1'b0;
      end else begin
        tx_busy = hold_busy;
      end
    end
  end

  // One request: idle = gap cycles before the command byte (>= TO means never sent),
  // k = cycles after enable rises before the sensor finishes, nj = cycle of a foreign finish,
  // ndrop = stray rx bytes during the wait, hold = tx_busy hold cycles before the response.
  task automatic run_txn(input logic [7:0] addr, input logic [7:0] cmd, input int idle,
                         input int k, input int nj, input int ndrop, input int hold,
                         input logic [7:0] sdata);
    logic [NS-1:0] onehot;
    logic [7:0]    exp_status;
    logic [7:0]    exp_data;
    int a, lim, high, exp_high, bad, drops;
    bit tmo;
    tx_q.delete();
    sensor_data = $urandom;
    a = int'(addr);
    rx_valid = 1'b1;
    rx_data  = addr;
    step();
    rx_valid = 1'b0;
    rx_data  = '0;
    check_eq("busy_after_addr", 32'(busy), 32'd1);

    if (idle >= int'(TO)) begin
      repeat (TO - 1) step();
      check_eq("getcmd_last_cycle", 32'(busy), 32'd1);
      step();
      exp_err++;
      check_eq("getcmd_timeout_idle", 32'(busy), 32'd0);
      repeat (4) step();
      check_eq("getcmd_no_tx", 32'(tx_q.size()), 32'd0);
      check_eq("err_count", 32'(error_count), 32'(sat(exp_err)));
      return;
    end

    repeat (idle) step();
    rx_valid = 1'b1;
    rx_data  = cmd;
    step();
    rx_valid = 1'b0;
    check_eq("enable_pre", 32'(sensor_enable), 32'd0);

    if (a >= int'(NS)) begin
      exp_status = STATUS_BAD_ADDR;
      exp_data   = 8'h00;
      exp_err++;
      step();
      check_eq("enable_bad_addr", 32'(sensor_enable), 32'd0);
    end else begin
      onehot = NS'(1) << a;
      sensor_data[a*DW +: DW] = sdata;
      step();
      check_eq("enable_onehot", 32'(sensor_enable), 32'(onehot));
      check_eq("request_cmd", 32'(sensor_request), 32'(cmd));
      tmo      = (k >= int'(TO));
      lim      = tmo ? int'(TO) - 1 : k;
      exp_high = tmo ? int'(TO) : k + 1;
      if (hold > 0) hold_busy = 1'b1;
      bad = 0; drops = 0; high = 0;
      for (int j = 0; j < 40; j++) begin
        sensor_finished = '0;
        if (j == k) sensor_finished[a] = 1'b1;
        if (j == nj && nj <= lim) sensor_finished[(a + 2) % int'(NS)] = 1'b1;
        rx_valid = (j < ndrop) && (j <= lim);
        rx_data  = DW'($urandom);
        if (rx_valid) drops++;
        step();
        sensor_finished = '0;
        rx_valid = 1'b0;
        if (sensor_enable == '0) begin
          high = j + 1;
          break;
        end
        if (sensor_enable != onehot || sensor_request != cmd) bad++;
      end
      check_eq("enable_cycles", 32'(high), 32'(exp_high));
      check_eq("enable_stable", 32'(bad), 32'd0);
      exp_err    += drops + (tmo ? 1 : 0);
      exp_status = tmo ? STATUS_TIMEOUT : STATUS_OK;
      exp_data   = tmo ? 8'h00 : sdata;
      if (hold > 0) begin
        repeat (hold) step();
        check_eq("no_tx_while_busy", 32'(tx_q.size()), 32'd0);
        hold_busy = 1'b0;
      end else begin
        step();
        check_eq("tx_start_latency", 32'(tx_start), 32'd1);
      end
    end

    for (int i = 0; i < 100; i++) begin
      if (tx_q.size() >= 2 && busy == 1'b0) break;
      step();
    end
    check_eq("resp_bytes", 32'(tx_q.size()), 32'(RESP_BYTES));
    if (tx_q.size() >= 2) begin
      check_eq("resp_status", 32'(tx_q[0]), 32'(exp_status));
      check_eq("resp_data", 32'(tx_q[1]), 32'(exp_data));
    end
    check_eq("busy_after_resp", 32'(busy), 32'd0);
    check_eq("err_count", 32'(error_count), 32'(sat(exp_err)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; exp_err = 0;
    hold_busy = 1'b0;
    reset_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;
    sensor_data = '0;
    sensor_finished = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_enable", 32'(sensor_enable), 32'd0);
    check_eq("rst_request", 32'(sensor_request), 32'd0);
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(error_count), 32'd0);
    reset_n = 1'b1;
    step();

    run_txn(8'h02, 8'hAA, 0, 5, -1, 0, 0, 8'h5C);
    run_txn(8'h07, 8'h01, 0, 0, -1, 0, 0, 8'h00);
    run_txn(8'h01, 8'h10, 0, 100, 3, 0, 0, 8'h00);
    run_txn(8'h00, 8'h00, 16, 0, -1, 0, 0, 8'h00);
    run_txn(8'h00, 8'h33, 0, 3, -1, 0, 0, 8'h42);
    run_txn(8'h03, 8'h21, 2, 10, -1, 3, 10, 8'h9D);
    run_txn(8'h01, 8'h44, 15, 15, 15, 1, 0, 8'hC3);

    for (int n = 0; n < 40; n++) begin
      run_txn(8'($urandom_range(0, 5)), 8'($urandom),
              ($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(0, 15)),
              int'($urandom_range(0, 20)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 8'($urandom));
    end

    // Asynchronous reset in the middle of a sensor wait.
    tx_q.delete();
    rx_valid = 1'b1;
    rx_data  = 8'h01;
    step();
    rx_data  = 8'h22;
    step();
    rx_valid = 1'b0;
    step();
    step();
    check_eq("pre_reset_enable", 32'(sensor_enable), 32'h2);
    step();
    #3 reset_n = 1'b0;
    #1;
    check_eq("async_rst_enable", 32'(sensor_enable), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("async_rst_err", 32'(error_count), 32'd0);
    exp_err = 0;
    step();
    reset_n = 1'b1;
    step();
    run_txn(8'h01, 8'h22, 3, 2, -1, 0, 0, 8'h99);

    // Drive the error counter well past its ceiling.
    while (exp_err < 300) begin
      run_txn(8'($urandom_range(4, 255)), 8'($urandom), 0, 0, -1, 0, 0, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sensor_request_router.md
Name: sensor_request_router

Overview:
Multi-channel request/response controller between the UART receive/transmit pair and up to NUM_SENSORS sensor decoders. It assembles a two-byte request (address, command) from the RX byte stream and drives a one-hot enable to the addressed sensor. It waits for that sensor's finished strobe with a timeout, then returns a two-byte response (status, data) through the TX handshake. It replaces the fixed single-device path with address validation, timeouts and error accounting.

Parameters:
NUM_SENSORS, 32, number of sensor channels (1..256)
DATA_WIDTH, 8, width of each sensor's data word and of UART bytes
TIMEOUT_CYCLES, 5000000, cycles allowed for the second request byte, and cycles allowed for the sensor to finish

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
rx_valid  input  1  one-cycle strobe, rx_data valid
rx_data  input  DATA_WIDTH  received byte
sensor_enable  output  NUM_SENSORS  one-hot enable, held for the whole wait
sensor_request  output  DATA_WIDTH  command byte for the sensor, stable while enabled
sensor_data  input  NUM_SENSORS*DATA_WIDTH  packed sensor results; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
sensor_finished  input  NUM_SENSORS  per-channel done strobe
tx_start  output  1  one-cycle pulse, send tx_data
tx_data  output  DATA_WIDTH  byte to transmit, stable from tx_start until tx_done
tx_busy  input  1  transmitter busy
tx_done  input  1  one-cycle strobe, byte sent
busy  output  1  high whenever state is not IDLE
error_count  output  8  saturating error counter

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - All outputs 0, timer 0, latched address/command/status/data 0.
  - sensor_enable drops immediately, without waiting for a clock edge.
- Status codes: OK=0x00, BAD_ADDR=0xE0, TIMEOUT=0xE1.
- FSM states and transitions:
  - IDLE: rx_valid -> latch address, clear timer, go GET_CMD.
  - GET_CMD: rx_valid -> latch command.
    - If address >= NUM_SENSORS: status=BAD_ADDR, data=0, error_count++, go SEND_STATUS.
    - Otherwise go DISPATCH.
    - Timer reaches TIMEOUT_CYCLES with no byte: error_count++, go IDLE, no response sent.
    - rx_valid in the same cycle as expiry: the byte wins.
  - DISPATCH: registers sensor_enable[address]=1 and sensor_request=command; clears timer; go WAIT_SENSOR. sensor_enable is high 2 cycles after the second rx_valid cycle.
  - WAIT_SENSOR:
    - sensor_finished[address] -> latch that channel's data slice, status=OK, clear sensor_enable, go SEND_STATUS.
    - finished from any other channel is ignored.
    - Expiry after TIMEOUT_CYCLES cycles: status=TIMEOUT, data=0, error_count++, clear enable, go SEND_STATUS.
    - finished in the same cycle as expiry: finished wins.
  - SEND_STATUS: when tx_busy=0, pulse tx_start for one cycle with tx_data=status, go WAIT_TX_STATUS. While tx_busy=1, wait indefinitely.
  - WAIT_TX_STATUS: tx_done -> go SEND_DATA.
  - SEND_DATA / WAIT_TX_DATA: same handshake with tx_data=data; tx_done -> IDLE.
- Latency: tx_start is asserted 2 cycles after the finished cycle when tx_busy=0.
- Dropped bytes: rx_valid in any state other than IDLE/GET_CMD drops the byte, increments error_count and leaves the transaction unaffected.
- error_count: saturates at 0xFF, never wraps. Cleared only by reset.
- Timer width: $clog2(TIMEOUT_CYCLES+1). The timer counts only in GET_CMD and WAIT_SENSOR.
- Address width: the full byte is compared against NUM_SENSORS, so no truncation aliasing.

Decomposition:
- Shared package sensor_hub_pkg holds:
  - state enum (IDLE, GET_CMD, DISPATCH, WAIT_SENSOR, SEND_STATUS, WAIT_TX_STATUS, SEND_DATA, WAIT_TX_DATA)
  - STATUS_OK, STATUS_BAD_ADDR, STATUS_TIMEOUT
  - request/response byte counts
- One sub-module, cycle_timeout:
  - inputs: clear and run
  - output: expired pulse at TIMEOUT_CYCLES
  - one instance, reused across both timed states.

Test Plan (NUM_SENSORS=4, TIMEOUT_CYCLES=16):
1. rx 0x02 then 0xAA; channel 2 raises finished 5 cycles later with data 0x5C -> sensor_enable=4'b0100 and sensor_request=0xAA until finished; TX bytes 0x00 then 0x5C; error_count=0; busy low after second tx_done.
2. rx 0x07, 0x01 -> sensor_enable stays 0; TX bytes 0xE0, 0x00; error_count=1.
3. rx 0x01, 0x10; channel 1 silent; channel 3 pulses finished with 0xFF -> channel 3 ignored; enable drops after 16 cycles; TX bytes 0xE1, 0x00; error_count=1.
4. rx 0x00 only, then idle 16 cycles -> back to IDLE, no tx_start, error_count=1; following request 0x00, 0x33 with finished data 0x42 returns 0x00, 0x42.
5. During WAIT_SENSOR inject 3 rx_valid bytes; hold tx_busy=1 for 10 cycles at SEND_STATUS -> error_count=3, response unchanged, tx_start only after tx_busy falls. Separately, force 300 errors -> error_count=0xFF.
6. Assert reset_n=0 mid WAIT_SENSOR between clock edges -> sensor_enable, busy, tx_start go 0 asynchronously; after release a fresh request completes normally.
